// File: rtl/comparator_1bit_data_if.sv
// Operand/result bundle for the magnitude compare cell.
// The master drives the operands and in_valid. The slave, which is the compare cell, drives the result flags.
interface comparator_1bit_data_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             GT;
    logic             EQ;
    logic             LT;
    logic             out_valid;

    modport master (
        output A, B, in_valid,
        input  GT, EQ, LT, out_valid
    );

    modport slave (
        input  A, B, in_valid,
        output GT, EQ, LT, out_valid
    );
endinterface

// File: rtl/comparator_1bit_data.sv
// Magnitude compare leaf cell with one-hot GT/EQ/LT flags.
// The outputs are combinational by default, or registered for a one-cycle latency.
module comparator_1bit_data #(
    parameter int WIDTH        = 1,
    parameter int SIGNED       = 0,
    parameter int REGISTER_OUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_1bit_data_if.slave bus
);
    // Flipping the sign bit maps two's complement onto unsigned order, so a single
    // unsigned compare serves both signedness settings.
    localparam logic [WIDTH-1:0] SIGN_FLIP =
        (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             gt_comb;
    logic             eq_comb;
    logic             lt_comb;

    assign a_key   = bus.A ^ SIGN_FLIP;
    assign b_key   = bus.B ^ SIGN_FLIP;
    assign gt_comb = (a_key > b_key);
    assign eq_comb = (a_key == b_key);
    assign lt_comb = (a_key < b_key);

    generate
        if (REGISTER_OUT != 0) begin : g_registered
            logic gt_reg;
            logic eq_reg;
            logic lt_reg;
            logic out_valid_reg;

            // The flags hold their last result while in_valid is low. out_valid follows in_valid one cycle later.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    gt_reg        <= 1'b0;
                    eq_reg        <= 1'b0;
                    lt_reg        <= 1'b0;
                    out_valid_reg <= 1'b0;
                end else begin
                    out_valid_reg <= bus.in_valid;
                    if (bus.in_valid) begin
                        gt_reg <= gt_comb;
                        eq_reg <= eq_comb;
                        lt_reg <= lt_comb;
                    end
                end
            end

            assign bus.GT        = gt_reg;
            assign bus.EQ        = eq_reg;
            assign bus.LT        = lt_reg;
            assign bus.out_valid = out_valid_reg;
        end else begin : g_combinational
            // In the dataflow build, clk and rst are deliberately left unconnected.
            wire unused_clk_rst = clk | rst;

            assign bus.GT        = gt_comb;
            assign bus.EQ        = eq_comb;
            assign bus.LT        = lt_comb;
            assign bus.out_valid = bus.in_valid;
        end
    endgenerate
endmodule

// File: tb/tb_comparator_1bit_data.sv
// Directed and random checks of comparator_1bit_data.
// The bench covers the combinational and registered builds, both signedness settings, and widths of 1, 4 and 8.
module tb_comparator_1bit_data;
    logic clk;
    logic rst_comb;
    logic rst_reg;
    int   tests_run;
    int   tests_failed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    comparator_1bit_data_if #(.WIDTH(1)) if_comb ();
    comparator_1bit_data_if #(.WIDTH(1)) if_reg  ();
    comparator_1bit_data_if #(.WIDTH(1)) if_w1s  ();
    comparator_1bit_data_if #(.WIDTH(4)) if_w4u  ();
    comparator_1bit_data_if #(.WIDTH(4)) if_w4s  ();
    comparator_1bit_data_if #(.WIDTH(8)) if_w8u  ();
    comparator_1bit_data_if #(.WIDTH(8)) if_w8s  ();

    comparator_1bit_data u_comb (.clk(clk), .rst(rst_comb), .bus(if_comb));
    comparator_1bit_data #(.WIDTH(1), .SIGNED(0), .REGISTER_OUT(1))
        u_reg (.clk(clk), .rst(rst_reg), .bus(if_reg));
    comparator_1bit_data #(.WIDTH(1), .SIGNED(1), .REGISTER_OUT(0))
        u_w1s (.clk(clk), .rst(rst_comb), .bus(if_w1s));
    comparator_1bit_data #(.WIDTH(4), .SIGNED(0), .REGISTER_OUT(0))
        u_w4u (.clk(clk), .rst(rst_comb), .bus(if_w4u));
    comparator_1bit_data #(.WIDTH(4), .SIGNED(1), .REGISTER_OUT(0))
        u_w4s (.clk(clk), .rst(rst_comb), .bus(if_w4s));
    comparator_1bit_data #(.WIDTH(8), .SIGNED(0), .REGISTER_OUT(0))
        u_w8u (.clk(clk), .rst(rst_comb), .bus(if_w8u));
    comparator_1bit_data #(.WIDTH(8), .SIGNED(1), .REGISTER_OUT(0))
        u_w8s (.clk(clk), .rst(rst_comb), .bus(if_w8s));

    // Each result is packed as the 4-bit vector {GT, EQ, LT, out_valid}.
    wire [3:0] r_comb = {if_comb.GT, if_comb.EQ, if_comb.LT, if_comb.out_valid};
    wire [3:0] r_reg  = {if_reg.GT,  if_reg.EQ,  if_reg.LT,  if_reg.out_valid};
    wire [3:0] r_w1s  = {if_w1s.GT,  if_w1s.EQ,  if_w1s.LT,  if_w1s.out_valid};
    wire [3:0] r_w4u  = {if_w4u.GT,  if_w4u.EQ,  if_w4u.LT,  if_w4u.out_valid};
    wire [3:0] r_w4s  = {if_w4s.GT,  if_w4s.EQ,  if_w4s.LT,  if_w4s.out_valid};
    wire [3:0] r_w8u  = {if_w8u.GT,  if_w8u.EQ,  if_w8u.LT,  if_w8u.out_valid};
    wire [3:0] r_w8s  = {if_w8s.GT,  if_w8s.EQ,  if_w8s.LT,  if_w8s.out_valid};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %b", tag, got);
        end
    endtask

    task automatic comb_vec(input string tag, input logic a, input logic b,
                            input logic v, input logic [3:0] exp);
        if_comb.A        = a;
        if_comb.B        = b;
        if_comb.in_valid = v;
        #2;
        check(tag, {4'b0, r_comb}, {4'b0, exp});
    endtask

    task automatic reg_drive(input logic a, input logic b, input logic v);
        if_reg.A        = a;
        if_reg.B        = b;
        if_reg.in_valid = v;
    endtask

    logic [7:0]        ra;
    logic [7:0]        rb;
    logic [3:0]        exp_u;
    logic [3:0]        exp_s;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_comb     = 1'b0;
        rst_reg      = 1'b1;
        if_comb.A = '0; if_comb.B = '0; if_comb.in_valid = 1'b0;
        if_reg.A  = '0; if_reg.B  = '0; if_reg.in_valid  = 1'b0;
        if_w1s.A  = '0; if_w1s.B  = '0; if_w1s.in_valid  = 1'b1;
        if_w4u.A  = '0; if_w4u.B  = '0; if_w4u.in_valid  = 1'b1;
        if_w4s.A  = '0; if_w4s.B  = '0; if_w4s.in_valid  = 1'b1;
        if_w8u.A  = '0; if_w8u.B  = '0; if_w8u.in_valid  = 1'b1;
        if_w8s.A  = '0; if_w8s.B  = '0; if_w8s.in_valid  = 1'b1;

        #2;
        check("reg_reset_state", {4'b0, r_reg}, 8'b0000_0000);

        // Default build: the four truth-table rows.
        comb_vec("comb_a0_b0", 1'b0, 1'b0, 1'b1, 4'b0101);
        comb_vec("comb_a0_b1", 1'b0, 1'b1, 1'b1, 4'b0011);
        comb_vec("comb_a1_b0", 1'b1, 1'b0, 1'b1, 4'b1001);
        comb_vec("comb_a1_b1", 1'b1, 1'b1, 1'b1, 4'b0101);
        comb_vec("comb_novalid", 1'b1, 1'b0, 1'b0, 4'b1000);

        // rst and clk activity must not disturb the dataflow build.
        rst_comb = 1'b1;
        @(posedge clk); #1;
        check("comb_rst_hold", {4'b0, r_comb}, 8'b0000_1000);
        comb_vec("comb_rst_a0_b1", 1'b0, 1'b1, 1'b1, 4'b0011);
        @(posedge clk); #1;
        rst_comb = 1'b0;
        comb_vec("comb_post_a1_b1", 1'b1, 1'b1, 1'b0, 4'b0100);
        comb_vec("comb_post_a1_b0", 1'b1, 1'b0, 1'b1, 4'b1001);

        // Registered build: one-cycle latency and hold while in_valid is low.
        @(negedge clk);
        rst_reg = 1'b0;
        reg_drive(1'b1, 1'b0, 1'b1);
        #1;
        check("reg_not_before_edge", {4'b0, r_reg}, 8'b0000_0000);
        @(posedge clk); #1;
        check("reg_gt_after_edge", {4'b0, r_reg}, 8'b0000_1001);
        @(negedge clk);
        reg_drive(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("reg_hold_novalid", {4'b0, r_reg}, 8'b0000_1000);

        // An asynchronous reset between edges clears the outputs immediately.
        @(negedge clk);
        reg_drive(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("reg_gt_again", {4'b0, r_reg}, 8'b0000_1001);
        #2;
        rst_reg = 1'b1;
        #1;
        check("reg_async_rst", {4'b0, r_reg}, 8'b0000_0000);
        @(posedge clk); #1;
        check("reg_rst_held", {4'b0, r_reg}, 8'b0000_0000);
        @(negedge clk);
        rst_reg = 1'b0;
        reg_drive(1'b1, 1'b1, 1'b1);
        #1;
        check("reg_rst_release", {4'b0, r_reg}, 8'b0000_0000);
        @(posedge clk); #1;
        check("reg_eq_first_edge", {4'b0, r_reg}, 8'b0000_0101);

        // The operands are sampled at the edge. Changes just after the edge must not leak into the result.
        @(negedge clk);
        reg_drive(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        reg_drive(1'b1, 1'b0, 1'b0);
        check("reg_edge_sample", {4'b0, r_reg}, 8'b0000_0011);
        @(posedge clk); #1;
        check("reg_edge_hold", {4'b0, r_reg}, 8'b0000_0010);

        // Back-to-back operands: one result per cycle.
        @(negedge clk); reg_drive(1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("reg_b2b_gt", {4'b0, r_reg}, 8'b0000_1001);
        @(negedge clk); reg_drive(1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("reg_b2b_eq", {4'b0, r_reg}, 8'b0000_0101);
        @(negedge clk); reg_drive(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("reg_b2b_lt", {4'b0, r_reg}, 8'b0000_0011);

        // Signed 1-bit: the value 1 means -1.
        if_w1s.A = 1'b1; if_w1s.B = 1'b0; #2;
        check("w1s_neg1_vs_0", {4'b0, r_w1s}, 8'b0000_0011);
        if_w1s.A = 1'b0; if_w1s.B = 1'b1; #2;
        check("w1s_0_vs_neg1", {4'b0, r_w1s}, 8'b0000_1001);

        // 4-bit boundary cases.
        if_w4u.A = 4'd15; if_w4u.B = 4'd0; #2;
        check("w4u_max_vs_0", {4'b0, r_w4u}, 8'b0000_1001);
        if_w4u.A = 4'b1000; if_w4u.B = 4'b0111; #2;
        check("w4u_8_vs_7", {4'b0, r_w4u}, 8'b0000_1001);
        if_w4u.A = 4'd0; if_w4u.B = 4'd0; #2;
        check("w4u_zero_eq", {4'b0, r_w4u}, 8'b0000_0101);
        if_w4s.A = 4'b1000; if_w4s.B = 4'b0111; #2;
        check("w4s_min_vs_max", {4'b0, r_w4s}, 8'b0000_0011);
        if_w4s.A = 4'b1111; if_w4s.B = 4'b1111; #2;
        check("w4s_ones_eq", {4'b0, r_w4s}, 8'b0000_0101);
        if_w4s.A = 4'b1111; if_w4s.B = 4'b0000; #2;
        check("w4s_neg1_vs_0", {4'b0, r_w4s}, 8'b0000_0011);

        // Random 8-bit vectors against a behavioural model, with the one-hot invariant checked on every vector.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = (i % 8 == 0) ? ra : 8'($urandom);
            if_w8u.A = ra; if_w8u.B = rb;
            if_w8s.A = ra; if_w8s.B = rb;
            #1;
            exp_u = {ra > rb, ra == rb, ra < rb, 1'b1};
            exp_s = {$signed(ra) > $signed(rb), $signed(ra) == $signed(rb),
                     $signed(ra) < $signed(rb), 1'b1};
            check($sformatf("w8u_%0d_%0d", ra, rb), {4'b0, r_w8u}, {4'b0, exp_u});
            check($sformatf("w8s_%0d_%0d", $signed(ra), $signed(rb)), {4'b0, r_w8s}, {4'b0, exp_s});
            check("w8u_onehot", 8'($countones(r_w8u[3:1])), 8'd1);
            check("w8s_onehot", 8'($countones(r_w8s[3:1])), 8'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
